// File: rtl/rs_bank_ctrl.sv
// rtl/rs_bank_ctrl.sv - round-robin write sequencer for a bank of RS latch cells
// Each write runs clear pulse, dead cycle, set pulse, then a readback check.
module rs_bank_ctrl #(
  parameter int W     = 4,
  parameter int PULSE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a,
  input  logic [W-1:0] data_a,
  input  logic         req_b,
  input  logic [W-1:0] data_b,
  input  logic [W-1:0] q_in,
  output logic [W-1:0] S,
  output logic [W-1:0] R,
  output logic         ack_a,
  output logic         ack_b,
  output logic         busy,
  output logic         err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] GAP   = 3'd2;
  localparam logic [2:0] SET   = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [3:0] PLOAD = 4'(PULSE - 1);

  logic [2:0]   state;
  logic [3:0]   cnt;
  logic         prio_a;
  logic         owner_b;
  logic [W-1:0] word_buf;
  logic         grant_b;

  // B wins when it is alone, or on a tie when A was granted last
  assign grant_b = req_b && (!req_a || !prio_a);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      prio_a   <= 1'b1;
      owner_b  <= 1'b0;
      word_buf <= '0;
      S        <= '0;
      R        <= '0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      err      <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            owner_b  <= grant_b;
            prio_a   <= grant_b;
            word_buf <= grant_b ? data_b : data_a;
            R        <= '1;
            S        <= '0;
            cnt      <= PLOAD;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          if (cnt == 4'd0) begin
            R     <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        GAP: begin
          // R was dropped on the previous edge, so S can never overlap it
          S     <= word_buf;
          cnt   <= PLOAD;
          state <= SET;
        end
        SET: begin
          if (cnt == 4'd0) begin
            S     <= '0;
            state <= CHECK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CHECK: begin
          err   <= (q_in != word_buf);
          ack_a <= !owner_b;
          ack_b <= owner_b;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          S     <= '0;
          R     <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_bank_ctrl.sv
// tb/tb_rs_bank_ctrl.sv - scoreboard bench for rs_bank_ctrl with timeline reference model
module tb_rs_bank_ctrl;
  localparam int W    = 4;
  localparam int P    = 2;
  localparam int LAST = 2 * P + 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_a, req_b;
  logic [W-1:0] data_a, data_b, q_in, S, R;
  logic         ack_a, ack_b, busy, err;

  always #5 clk = ~clk;

  rs_bank_ctrl #(.W(W), .PULSE(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b),
    .q_in(q_in), .S(S), .R(R),
    .ack_a(ack_a), .ack_b(ack_b), .busy(busy), .err(err)
  );

  // Latch bank environment; fault forces the readback to all zeros
  logic [W-1:0] q_lat = '0;
  logic         fault = 1'b0;
  always @(posedge clk) q_lat <= (q_lat & ~R) | S;
  assign q_in = fault ? '0 : q_lat;

  typedef struct { logic owner_b; logic err; } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int passes = 0;

  // Reference model: n counts edges since grant (0 = idle)
  int           n = 0;
  logic         m_owner_b = 1'b0;
  logic [W-1:0] m_word = '0;
  logic         m_err = 1'b0;
  logic         m_cur_err = 1'b0;
  logic         m_prio_a = 1'b1;
  logic         fault_next = 1'b0;
  logic         pend_a = 1'b0, pend_b = 1'b0;
  logic         started = 1'b0;
  logic [W-1:0] prev_r = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    logic [W-1:0] exp_r, exp_s;
    if (!rst_n) begin
      if (n >= 1 && n < LAST && sb.size() > 0) sb.delete(sb.size() - 1);
      n = 0;
      m_prio_a = 1'b1;
      m_err = 1'b0;
    end else if (n == 0) begin
      if (req_a || req_b) begin
        m_owner_b = req_b && !(req_a && m_prio_a);
        m_prio_a  = m_owner_b;
        m_word    = m_owner_b ? data_b : data_a;
        fault     = fault_next;
        m_cur_err = fault_next && (m_word != '0);
        sb.push_back('{m_owner_b, m_cur_err});
        n = 1;
      end
    end else if (n == LAST) begin
      n = 0;
    end else begin
      n++;
      if (n == LAST) m_err = m_cur_err;
    end
    @(posedge clk);
    #1;
    exp_r = (n >= 1 && n <= P) ? {W{1'b1}} : '0;
    exp_s = (n >= P + 2 && n <= 2 * P + 1) ? m_word : '0;
    chk("R", R, exp_r);
    chk("S", S, exp_s);
    chk("ack_a", ack_a, (n == LAST) && !m_owner_b);
    chk("ack_b", ack_b, (n == LAST) && m_owner_b);
    chk("busy", busy, n != 0);
    chk("err", err, m_err);
    if (!rst_n) begin
      req_a = 1'b0; req_b = 1'b0; pend_a = 1'b0; pend_b = 1'b0;
    end
    if (n == LAST) begin
      if (m_owner_b) begin req_b = 1'b0; pend_b = 1'b0; end
      else begin req_a = 1'b0; pend_a = 1'b0; end
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each ack
  always @(negedge clk) begin
    if (started) begin
      chk("s_and_r", 32'(S & R), 0);
      chk("r_to_s_gap", 32'(prev_r & S), 0);
      chk("ack_onehot", 32'(ack_a & ack_b), 0);
      if (ack_a || ack_b) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", {ack_a, ack_b}, 0);
        end else begin
          e = sb.pop_front();
          chk("ack_owner", ack_b, e.owner_b);
          chk("ack_err", err, e.err);
        end
      end
      prev_r = R;
    end
  end

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
    step();
    started = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (10) step();

    req_a = 1'b1; data_a = 4'b1010; pend_a = 1'b1;
    repeat (LAST + 1) step();

    rst_n = 1'b0; step(); rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1; data_a = 4'h3; data_b = 4'hC;
    pend_a = 1'b1; pend_b = 1'b1;
    repeat (LAST) step();
    req_a = 1'b1; data_a = 4'h5; pend_a = 1'b1;
    repeat (LAST + 1) step();
    repeat (LAST + 1) step();

    fault_next = 1'b1; req_b = 1'b1; data_b = 4'b0110; pend_b = 1'b1;
    repeat (LAST + 1) step();
    fault_next = 1'b0; req_a = 1'b1; data_a = 4'h9; pend_a = 1'b1;
    repeat (LAST + 1) step();

    req_a = 1'b1; data_a = 4'hF; pend_a = 1'b1;
    repeat (P + 2) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req_a = 1'b1; data_a = 4'h6; pend_a = 1'b1;
    repeat (LAST + 1) step();

    repeat (2000) begin
      if (!pend_a && $urandom_range(3) == 0) begin pend_a = 1'b1; req_a = 1'b1; data_a = W'($urandom); end
      if (!pend_b && $urandom_range(3) == 0) begin pend_b = 1'b1; req_b = 1'b1; data_b = W'($urandom); end
      if (n > 0 && n < LAST) begin
        if (m_owner_b) begin
          data_b = W'($urandom);
          if ($urandom_range(7) == 0) req_b = 1'b0;
        end else begin
          data_a = W'($urandom);
          if ($urandom_range(7) == 0) req_a = 1'b0;
        end
      end
      fault_next = ($urandom_range(7) == 0);
      rst_n = ($urandom_range(299) != 0);
      step();
    end

    rst_n = 1'b1;
    for (int i = 0; i < 40 && (n != 0 || pend_a || pend_b); i++) step();
    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
